// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - MIPS-subset instruction encoder and IM loader
// Define PSEUDO_LI_EN to expand mnem 11 (li) into a lui/ori word pair.
module mips_instr_encoder #(
    parameter int          IM_DEPTH = 1024,
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] BASE_PC  = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    input  logic [25:0]       target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [31:0]       pc_out,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IM_DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(IM_DEPTH - 1);

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [ADDR_W:0]   r_count;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_is_li;
    logic              w_idle;
    logic              w_full;
    logic              w_accept;

`ifdef PSEUDO_LI_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_EMIT2 = 1'b1;

    logic [0:0]  r_state;
    logic [4:0]  r_li_rt;
    logic [15:0] r_li_lo;

    assign w_idle = (r_state == S_IDLE);
`else
    assign w_idle = 1'b1;
`endif

    assign w_full   = (r_count == DEPTH_C);
    assign w_accept = in_valid && in_ready;
    assign w_is_li  = (mnem == 4'd11);

    // li's first word is the lui half; it is only emitted when li is legal.
    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        case (mnem)
            4'd0:  w_word = {6'h00, rs, rt, rd, 5'b0, 6'h21};
            4'd1:  w_word = {6'h00, rs, rt, rd, 5'b0, 6'h23};
            4'd2:  w_word = {6'h0D, rs, rt, imm[15:0]};
            4'd3:  w_word = {6'h23, rs, rt, imm[15:0]};
            4'd4:  w_word = {6'h2B, rs, rt, imm[15:0]};
            4'd5:  w_word = {6'h04, rs, rt, imm[15:0]};
            4'd6:  w_word = {6'h0F, 5'b0, rt, imm[15:0]};
            4'd7:  w_word = {6'h02, target};
            4'd8:  w_word = {6'h03, target};
            4'd9:  w_word = {6'h00, rs, 15'b0, 6'h08};
            4'd10: w_word = 32'h0;
            4'd11: begin
                w_word = {6'h0F, 5'b0, rt, imm[31:16]};
`ifdef PSEUDO_LI_EN
                w_legal = 1'b1;
`else
                w_legal = 1'b0;
`endif
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_count <= '0;
`ifdef PSEUDO_LI_EN
            r_state <= S_IDLE;
            r_li_rt <= 5'd0;
            r_li_lo <= 16'h0;
`endif
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
`ifdef PSEUDO_LI_EN
            if (r_state == S_EMIT2) begin
                r_we    <= 1'b1;
                r_addr  <= r_count[ADDR_W-1:0];
                r_wdata <= {6'h0D, r_li_rt, r_li_rt, r_li_lo};
                r_count <= r_count + 1'b1;
                r_state <= S_IDLE;
            end else
`endif
            if (w_accept) begin
                // li needs two free slots; refuse it whole rather than split it.
                if (!w_legal || (w_is_li && r_count == LAST_C)) begin
                    r_err <= 1'b1;
                end else begin
                    r_we    <= 1'b1;
                    r_addr  <= r_count[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_count <= r_count + 1'b1;
`ifdef PSEUDO_LI_EN
                    if (w_is_li) begin
                        r_state <= S_EMIT2;
                        r_li_rt <= rt;
                        r_li_lo <= imm[15:0];
                    end
`endif
                end
            end
        end
    end

    assign in_ready = w_idle && !w_full;
    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign full     = w_full;
    assign err      = r_err;
    assign pc_out   = BASE_PC + {{(29-ADDR_W){1'b0}}, r_count, 2'b00};

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - directed bench for mips_instr_encoder
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        a_reset, b_reset, a_valid, b_valid;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [25:0] target;

    logic        a_ready, a_we, a_full, a_err;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_pc;
    logic        b_ready, b_we, b_full, b_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata, b_pc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_instr_encoder dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_valid), .in_ready(a_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata), .pc_out(a_pc),
        .full(a_full), .err(a_err)
    );

    mips_instr_encoder #(.IM_DEPTH(4), .ADDR_W(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_valid), .in_ready(b_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata), .pc_out(b_pc),
        .full(b_full), .err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [31:0] i, input logic [25:0] tg);
        mnem = m; rs = s; rt = t; rd = d; imm = i; target = tg;
    endtask

    task automatic reset_a();
        a_valid = 1'b0; a_reset = 1'b1;
        step();
        a_reset = 1'b0;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        set_instr(4'd10, 0, 0, 0, 0, 0);
        step(); step();
        a_reset = 1'b0; b_reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        n_tests++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", a_ready); end
        n_tests++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", a_we); end
        n_tests++; if (a_addr !== 10'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", a_addr); end
        n_tests++; if (a_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", a_wdata); end
        n_tests++; if (a_pc !== 32'h00003000) begin n_fail++; $display("FAIL reset_pc got %h want 00003000", a_pc); end
        n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", a_full); end
        n_tests++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", a_err); end
    endtask

    task automatic test_addu();
        reset_a();
        set_instr(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        n_tests++; if (a_we !== 1'b1) begin n_fail++; $display("FAIL addu_we got %b want 1", a_we); end
        n_tests++; if (a_wdata !== 32'h00221821) begin n_fail++; $display("FAIL addu_wdata got %h want 00221821", a_wdata); end
        n_tests++; if (a_addr !== 10'd0) begin n_fail++; $display("FAIL addu_addr got %h want 0", a_addr); end
        n_tests++; if (a_pc !== 32'h00003004) begin n_fail++; $display("FAIL addu_pc got %h want 00003004", a_pc); end
        step();
        n_tests++; if (a_we !== 1'b0) begin n_fail++; $display("FAIL addu_we_drop got %b want 0", a_we); end
    endtask

    task automatic test_back_to_back();
        reset_a();
        set_instr(4'd2, 5'd0, 5'd1, 5'd0, 32'h0000_1234, 26'h0);
        a_valid = 1'b1;
        step();
        set_instr(4'd9, 5'd31, 5'd0, 5'd0, 32'h0, 26'h0);
        n_tests++; if (a_we !== 1'b1 || a_addr !== 10'd0 || a_wdata !== 32'h34011234) begin
            n_fail++; $display("FAIL b2b_ori got we=%b addr=%h data=%h want 1/0/34011234", a_we, a_addr, a_wdata); end
        step();
        a_valid = 1'b0;
        n_tests++; if (a_we !== 1'b1 || a_addr !== 10'd1 || a_wdata !== 32'h03E00008) begin
            n_fail++; $display("FAIL b2b_jr got we=%b addr=%h data=%h want 1/1/03e00008", a_we, a_addr, a_wdata); end
        n_tests++; if (a_pc !== 32'h00003008) begin n_fail++; $display("FAIL b2b_pc got %h want 00003008", a_pc); end
    endtask

    task automatic test_li();
        reset_a();
        set_instr(4'd11, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 26'h0);
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        set_instr(4'd0, 5'd7, 5'd9, 5'd4, 32'hDEAD_BEEF, 26'h0);
`ifdef PSEUDO_LI_EN
        n_tests++; if (a_we !== 1'b1 || a_addr !== 10'd0 || a_wdata !== 32'h3C081234) begin
            n_fail++; $display("FAIL li_lui got we=%b addr=%h data=%h want 1/0/3c081234", a_we, a_addr, a_wdata); end
        n_tests++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL li_ready_low got %b want 0", a_ready); end
        step();
        n_tests++; if (a_we !== 1'b1 || a_addr !== 10'd1 || a_wdata !== 32'h35085678) begin
            n_fail++; $display("FAIL li_ori got we=%b addr=%h data=%h want 1/1/35085678", a_we, a_addr, a_wdata); end
        n_tests++; if (a_ready !== 1'b1 || a_pc !== 32'h00003008) begin
            n_fail++; $display("FAIL li_done got ready=%b pc=%h want 1/00003008", a_ready, a_pc); end
`else
        n_tests++; if (a_err !== 1'b1 || a_we !== 1'b0) begin
            n_fail++; $display("FAIL li_illegal got err=%b we=%b want 1/0", a_err, a_we); end
        n_tests++; if (a_pc !== 32'h00003000) begin n_fail++; $display("FAIL li_illegal_pc got %h want 00003000", a_pc); end
`endif
    endtask

    task automatic test_jal_illegal();
        reset_a();
        set_instr(4'd8, 5'd0, 5'd0, 5'd0, 32'h0, 26'h0000C00);
        a_valid = 1'b1;
        step();
        set_instr(4'd15, 5'd1, 5'd2, 5'd3, 32'hFFFF, 26'h0);
        n_tests++; if (a_we !== 1'b1 || a_wdata !== 32'h0C000C00) begin
            n_fail++; $display("FAIL jal got we=%b data=%h want 1/0c000c00", a_we, a_wdata); end
        step();
        a_valid = 1'b0;
        n_tests++; if (a_err !== 1'b1 || a_we !== 1'b0) begin
            n_fail++; $display("FAIL illegal got err=%b we=%b want 1/0", a_err, a_we); end
        n_tests++; if (a_pc !== 32'h00003004) begin n_fail++; $display("FAIL illegal_pc got %h want 00003004", a_pc); end
        step();
        n_tests++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse got %b want 0", a_err); end
    endtask

    task automatic test_small_depth();
        b_valid = 1'b0; b_reset = 1'b1;
        step();
        b_reset = 1'b0;
        set_instr(4'd10, 0, 0, 0, 0, 0);
        b_valid = 1'b1;
        step(); step(); step();
        set_instr(4'd11, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 26'h0);
        n_tests++; if (b_pc !== 32'h0000300C || b_addr !== 2'd2) begin
            n_fail++; $display("FAIL small_three got pc=%h addr=%h want 0000300c/2", b_pc, b_addr); end
        step();
        set_instr(4'd10, 0, 0, 0, 0, 0);
        n_tests++; if (b_err !== 1'b1 || b_we !== 1'b0 || b_pc !== 32'h0000300C) begin
            n_fail++; $display("FAIL small_li got err=%b we=%b pc=%h want 1/0/0000300c", b_err, b_we, b_pc); end
        step();
        n_tests++; if (b_we !== 1'b1 || b_addr !== 2'd3 || b_full !== 1'b1 || b_ready !== 1'b0) begin
            n_fail++; $display("FAIL small_full got we=%b addr=%h full=%b ready=%b want 1/3/1/0", b_we, b_addr, b_full, b_ready); end
        n_tests++; if (b_pc !== 32'h00003010) begin n_fail++; $display("FAIL small_pc got %h want 00003010", b_pc); end
        step();
        n_tests++; if (b_we !== 1'b0 || b_err !== 1'b0) begin
            n_fail++; $display("FAIL small_blocked1 got we=%b err=%b want 0/0", b_we, b_err); end
        step();
        b_valid = 1'b0;
        n_tests++; if (b_we !== 1'b0 || b_err !== 1'b0 || b_full !== 1'b1) begin
            n_fail++; $display("FAIL small_blocked2 got we=%b err=%b full=%b want 0/0/1", b_we, b_err, b_full); end
    endtask

    task automatic test_reset_mid();
        reset_a();
`ifdef PSEUDO_LI_EN
        set_instr(4'd11, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 26'h0);
`else
        set_instr(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
`endif
        a_valid = 1'b1;
        step();
        a_reset = 1'b1;
        set_instr(4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 26'h0);
        step();
        a_reset = 1'b0; a_valid = 1'b0;
        n_tests++; if (a_we !== 1'b0 || a_pc !== 32'h00003000 || a_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid got we=%b pc=%h ready=%b want 0/00003000/1", a_we, a_pc, a_ready); end
        step();
        n_tests++; if (a_we !== 1'b0 || a_pc !== 32'h00003000) begin
            n_fail++; $display("FAIL reset_mid_after got we=%b pc=%h want 0/00003000", a_we, a_pc); end
    endtask

    initial begin
        test_reset();
        test_addu();
        test_back_to_back();
        test_li();
        test_jal_illegal();
        test_small_depth();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS-subset instruction encoder and instruction-memory loader for the P4 single-cycle CPU test infrastructure. Accepts one symbolic instruction per valid/ready handshake, packs the 32-bit machine word for the same instruction subset the control decoder supports, and writes it into consecutive instruction-memory words starting at the boot PC. It sits between bench or boot-loader logic and the IM write port, and produces the images that the CPU then fetches and decodes.

## Interface
- IM_DEPTH, 1024: IM capacity in 32-bit words; at most IM_DEPTH words are written.
- ADDR_W, 10: width of `im_addr`; satisfies 2^ADDR_W >= IM_DEPTH.
- BASE_PC, 32'h0000_3000: byte address of IM word 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept; transfer occurs when in_valid && in_ready at a rising edge.
- mnem  in  4  0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 j, 8 jal, 9 jr, 10 nop, 11 li (pseudo), 12-15 illegal.
- rs, rt, rd  in  5 each  register fields.
- imm  in  32  immediate; only [15:0] is used, except by li.
- target  in  26  jump target field for j/jal.
- im_we  out  1  IM write strobe, one cycle per word.
- im_addr  out  ADDR_W  word index being written.
- im_wdata  out  32  encoded word.
- pc_out  out  32  byte address of next free slot: BASE_PC + 4*count.
- full  out  1  count == IM_DEPTH.
- err  out  1  one-cycle pulse for a rejected request.

## Operation
- Encodings: R-type is {6'b0, rs, rt, rd, 5'b0, func}, with addu func 6'h21, subu 6'h23, jr {6'b0, rs, 15'b0, 6'h08}. I-type is {op, rs, rt, imm[15:0]}, with ori 6'h0D, lw 6'h23, sw 6'h2B, beq 6'h04, and lui 6'h0F (rs forced 0). J-type is {op, target}, with j 6'h02 and jal 6'h03. nop is 32'h0.
- Internal counter `count` runs 0..IM_DEPTH, width ADDR_W+1.
- States: IDLE and EMIT2. in_ready = (state == IDLE) && !full.
  - IDLE, legal single-word accept: register word, im_we=1 next cycle, im_addr=count, count+1; remain IDLE.
  - IDLE, li accept (only with macro): first word lui rt, imm[31:16]; go to EMIT2.
  - EMIT2: second word ori rt, rt, imm[15:0]; return to IDLE.
  - Illegal mnem accepted: err=1 next cycle, no write, count unchanged.
  - li accepted with count == IM_DEPTH-1: err, no write. li is atomic.
- Fields of li are latched at accept; input changes during EMIT2 are ignored.
- When full, in_ready=0, requests are not accepted, and no err is raised.

## Timing
- Reset values: in_ready=1, im_we=0, im_addr=0, im_wdata=0, pc_out=BASE_PC, full=0, err=0, state IDLE, count=0.
- Latency: accept at edge N gives im_we/im_addr/im_wdata valid during cycle N+1.
- For li, the words appear in cycles N+1 and N+2, and in_ready=0 during N+1.
- Back-to-back single-word accepts give one write per cycle.
- pc_out and full update in the same cycle as the im_we they account for.
- Reset in EMIT2: the second word is dropped, and all state returns to reset values on that edge.
- reset dominates in_valid in the same cycle.

## Configuration
- PSEUDO_LI_EN defined: mnem 11 expands to the two-word lui/ori sequence, and the EMIT2 state exists.
- PSEUDO_LI_EN undefined: mnem 11 is illegal (err pulse, no write), EMIT2 is not built, and in_ready = !full.

## Test plan
- addu rd=3, rs=1, rt=2 after reset -> im_wdata=32'h00221821, im_addr=0, pc_out becomes 32'h00003004.
- Back-to-back ori rt=1, rs=0, imm=16'h1234, then jr rs=31 -> words 32'h34011234 at addr 0 and 32'h03E00008 at addr 1 on consecutive cycles.
- With PSEUDO_LI_EN, li rt=8, imm=32'h12345678 -> 32'h3C081234 then 32'h35085678; in_ready low for one cycle. Without the macro: err pulse, no im_we.
- jal target=26'h0000C00 -> 32'h0C000C00; illegal mnem=15 -> err=1 for one cycle, no write, pc_out unchanged.
- IM_DEPTH=4: three nops, then li -> err, no write. One more nop -> full=1, in_ready=0. Further in_valid produces no im_we and no err.
- Assert reset during EMIT2 -> no second write, im_we=0, pc_out=BASE_PC, in_ready=1 next cycle.
